// File: rtl/hb_io_pkg.sv
// Shared definitions for the Hummingbird I/O-bus UART transmit port.
// HB_UART_PARITY_EN adds the PARITY state to the transmitter FSM.
package hb_io_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_DIV    = 2'd1;
  localparam logic [1:0] ADDR_DIV_RB = 2'd2;

  localparam int STAT_IDLE = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OVF  = 2;
  localparam int STAT_PAR  = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef HB_UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/hb_byte_fifo.sv
// Synchronous byte FIFO; read data is the head entry, valid in the same cycle as pop.
// A push while full is accepted only if a pop frees the slot in the same cycle.
module hb_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hb_uart_tx_port.sv
// Hummingbird output-device UART: CPU writes fill a byte FIFO drained as 8N1 serial frames.
// Build with HB_UART_PARITY_EN for an even-parity bit between data and stop.
module hb_uart_tx_port
  import hb_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET  = 16,
  parameter int DIV_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dev_wr_b,
  input  logic       dev_rd_b,
  input  logic [1:0] dev_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rdata_en,
  output logic       txd,
  output logic       busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RESET);

  logic             wr_en, rd_en;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;
  logic [CW-1:0]    fifo_count;
  logic [DIV_W-1:0] div_q, eff_div;
  logic             ovf_q;
  logic [7:0]       status;

  tx_state_e        state, state_d;
  logic [DIV_W-1:0] cnt, cnt_d;
  logic [DIV_W-1:0] bdiv, bdiv_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shift, shift_d;
  logic             bit_end;
  logic             load;
`ifdef HB_UART_PARITY_EN
  logic             par_q, par_d;
`endif

  assign wr_en     = !dev_wr_b;
  assign rd_en     = !dev_rd_b;
  assign fifo_push = wr_en && (dev_addr == ADDR_DATA);
  assign eff_div   = (div_q == '0) ? DIV_ONE : div_q;
  assign bit_end   = (cnt == bdiv - DIV_ONE);
  assign busy      = !fifo_empty || (state != ST_IDLE);
  assign rdata_en  = rd_en;

  hb_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Overflow set wins over a same-cycle status read so no drop goes unreported.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DIV_INIT;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en && dev_addr == ADDR_DIV) div_q <= wdata[DIV_W-1:0];
      if (fifo_push && fifo_full && !fifo_pop) ovf_q <= 1'b1;
      else if (rd_en && dev_addr == ADDR_DATA) ovf_q <= 1'b0;
    end
  end

  always_comb begin
    status            = '0;
    status[STAT_IDLE] = (state == ST_IDLE);
    status[STAT_FULL] = fifo_full;
    status[STAT_OVF]  = ovf_q;
`ifdef HB_UART_PARITY_EN
    status[STAT_PAR]  = 1'b1;
`endif
  end

  always_comb begin
    case (dev_addr)
      ADDR_DATA:   rdata = status;
      ADDR_DIV:    rdata = 8'(fifo_count);
      ADDR_DIV_RB: rdata = 8'(div_q);
      default:     rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bdiv    <= DIV_ONE;
      bit_idx <= '0;
      shift   <= '0;
`ifdef HB_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bdiv    <= bdiv_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
`ifdef HB_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bdiv_d    = bdiv;
    bit_idx_d = bit_idx;
    shift_d   = shift;
`ifdef HB_UART_PARITY_EN
    par_d     = par_q;
`endif
    load      = 1'b0;
    fifo_pop  = 1'b0;
    txd       = 1'b1;

    if (state != ST_IDLE) cnt_d = bit_end ? '0 : cnt + DIV_ONE;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        txd = 1'b0;
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        txd = shift[0];
        if (bit_end) begin
          shift_d = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
`ifdef HB_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
`ifdef HB_UART_PARITY_EN
      ST_PARITY: begin
        txd = par_q;
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) load = 1'b1;
          else state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Divisor is latched per frame so mid-frame writes only affect later frames.
    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      bdiv_d   = eff_div;
      cnt_d    = '0;
      state_d  = ST_START;
`ifdef HB_UART_PARITY_EN
      par_d    = ^fifo_rdata;
`endif
    end
  end

endmodule

// File: tb/tb_hb_uart_tx_port.sv
// Bench for hb_uart_tx_port: per-clock txd expectations are queued as bytes are pushed.
// Valid with or without HB_UART_PARITY_EN defined.
module tb_hb_uart_tx_port;

  localparam int DEPTH = 8;
`ifdef HB_UART_PARITY_EN
  localparam int FBITS = 11;
  localparam logic [7:0] PAR_BIT = 8'h08;
`else
  localparam int FBITS = 10;
  localparam logic [7:0] PAR_BIT = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dev_wr_b = 1'b1;
  logic       dev_rd_b = 1'b1;
  logic [1:0] dev_addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       rdata_en;
  logic       txd;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  hb_uart_tx_port #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16), .DIV_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .dev_wr_b (dev_wr_b),
    .dev_rd_b (dev_rd_b),
    .dev_addr (dev_addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rdata_en (rdata_en),
    .txd      (txd),
    .busy     (busy)
  );

  // Expected line level for every clock of one frame.
  function automatic void push_frame(input logic [7:0] b, input int div);
    logic [FBITS-1:0] f;
    int d;
    d = (div == 0) ? 1 : div;
    f = '0;
    f[0] = 1'b0;
    f[8:1] = b;
`ifdef HB_UART_PARITY_EN
    f[9] = ^b;
`endif
    f[FBITS-1] = 1'b1;
    for (int i = 0; i < FBITS; i++)
      for (int j = 0; j < d; j++) exp_q.push_back(f[i]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    dev_wr_b = 1'b0;
    dev_addr = a;
    wdata    = d;
    tick();
    dev_wr_b = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    dev_rd_b = 1'b0;
    dev_addr = a;
    #1;
    d = rdata;
    tick();
    dev_rd_b = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b want 1", txd); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    dev_rd_b = 1'b0;
    dev_addr = 2'd0;
    #1;
    vectors++; if (rdata_en !== 1'b1) begin miscompares++; $display("FAIL reset_rden: got %b want 1", rdata_en); end
    vectors++; if (rdata !== (8'h01 | PAR_BIT)) begin miscompares++; $display("FAIL reset_status: got %h want %h", rdata, 8'h01 | PAR_BIT); end
    tick();
    dev_rd_b = 1'b1;
    #1;
    vectors++; if (rdata_en !== 1'b0) begin miscompares++; $display("FAIL reset_rden_off: got %b want 0", rdata_en); end
    rd(2'd2, d);
    vectors++; if (d !== 8'd16) begin miscompares++; $display("FAIL reset_div: got %0d want 16", d); end
    rd(2'd1, d);
    vectors++; if (d !== 8'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", d); end
    rd(2'd3, d);
    vectors++; if (d !== 8'd0) begin miscompares++; $display("FAIL reset_addr3: got %h want 00", d); end
  endtask

  task automatic test_single_frame();
    logic [0:0] e;
    int idx;
    wr(2'd1, 8'd4);
    exp_q.delete();
    push_frame(8'hA5, 4);
    wr(2'd0, 8'hA5);
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      vectors++; if (txd !== e) begin miscompares++; $display("FAIL a5_txd[%0d]: got %b want %b", idx, txd, e); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL a5_busy[%0d]: got %b want 1", idx, busy); end
      idx++;
    end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL a5_busy_end: got %b want 0", busy); end
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL a5_txd_end: got %b want 1", txd); end
  endtask

  task automatic test_back_to_back();
    logic [0:0] e;
    int idx;
    int fl;
    fl = FBITS * 2;
    wr(2'd1, 8'd2);
    exp_q.delete();
    push_frame(8'h00, 2);
    push_frame(8'hFF, 2);
    push_frame(8'h55, 2);
    dev_wr_b = 1'b0; dev_addr = 2'd0; wdata = 8'h00;
    tick();
    wdata = 8'hFF;
    tick();
    e = exp_q.pop_front();
    vectors++; if (txd !== e) begin miscompares++; $display("FAIL b2b_txd[0]: got %b want %b", txd, e); end
    wdata = 8'h55;
    tick();
    e = exp_q.pop_front();
    vectors++; if (txd !== e) begin miscompares++; $display("FAIL b2b_txd[1]: got %b want %b", txd, e); end
    dev_wr_b = 1'b1; dev_rd_b = 1'b0; dev_addr = 2'd1;
    #1;
    vectors++; if (rdata !== 8'd2) begin miscompares++; $display("FAIL b2b_count0: got %0d want 2", rdata); end
    idx = 2;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      vectors++; if (txd !== e) begin miscompares++; $display("FAIL b2b_txd[%0d]: got %b want %b", idx, txd, e); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy[%0d]: got %b want 1", idx, busy); end
      if (idx == fl) begin
        vectors++; if (rdata !== 8'd1) begin miscompares++; $display("FAIL b2b_count1: got %0d want 1", rdata); end
      end
      if (idx == 2 * fl) begin
        vectors++; if (rdata !== 8'd0) begin miscompares++; $display("FAIL b2b_count2: got %0d want 0", rdata); end
      end
      idx++;
    end
    dev_rd_b = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_overflow();
    logic [7:0] b [10];
    logic [0:0] e;
    int k;
    int idx;
    wr(2'd1, 8'd4);
    for (int i = 0; i < 10; i++) b[i] = 8'($urandom_range(0, 255));
    exp_q.delete();
    for (int i = 1; i < 9; i++) push_frame(b[i], 4);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      dev_wr_b = 1'b0; dev_addr = 2'd0; wdata = b[i];
      tick();
      if (i == 0) k = cyc_n;
    end
    dev_wr_b = 1'b1;
    dev_rd_b = 1'b0; dev_addr = 2'd1;
    #1;
    vectors++; if (rdata !== 8'(DEPTH)) begin miscompares++; $display("FAIL ovf_count: got %0d want %0d", rdata, DEPTH); end
    dev_addr = 2'd0;
    #1;
    vectors++; if (rdata !== (8'h06 | PAR_BIT)) begin miscompares++; $display("FAIL ovf_status: got %h want %h", rdata, 8'h06 | PAR_BIT); end
    tick();
    vectors++; if (rdata !== (8'h02 | PAR_BIT)) begin miscompares++; $display("FAIL ovf_cleared: got %h want %h", rdata, 8'h02 | PAR_BIT); end
    dev_rd_b = 1'b1;
    while (cyc_n < k + FBITS * 4) tick();
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      vectors++; if (txd !== e) begin miscompares++; $display("FAIL ovf_txd[%0d]: got %b want %b", idx, txd, e); end
      idx++;
    end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ovf_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_divisor_change();
    logic [7:0] x, y, z, d;
    logic [0:0] e;
    int idx;
    x = 8'($urandom_range(0, 255));
    y = 8'($urandom_range(0, 255));
    z = 8'($urandom_range(0, 255));
    wr(2'd1, 8'd4);
    exp_q.delete();
    push_frame(x, 4);
    push_frame(y, 8);
    wr(2'd0, x);
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      vectors++; if (txd !== e) begin miscompares++; $display("FAIL div_txd[%0d]: got %b want %b", idx, txd, e); end
      dev_wr_b = 1'b1;
      if (idx == 4) begin dev_wr_b = 1'b0; dev_addr = 2'd1; wdata = 8'd8; end
      if (idx == 5) begin dev_wr_b = 1'b0; dev_addr = 2'd0; wdata = y; end
      idx++;
    end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL div_busy_end: got %b want 0", busy); end
    rd(2'd2, d);
    vectors++; if (d !== 8'd8) begin miscompares++; $display("FAIL div_readback: got %0d want 8", d); end
    wr(2'd1, 8'd0);
    rd(2'd2, d);
    vectors++; if (d !== 8'd0) begin miscompares++; $display("FAIL div0_readback: got %0d want 0", d); end
    exp_q.delete();
    push_frame(z, 0);
    wr(2'd0, z);
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      vectors++; if (txd !== e) begin miscompares++; $display("FAIL div0_txd[%0d]: got %b want %b", idx, txd, e); end
      idx++;
    end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL div0_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic [0:0] e;
    wr(2'd1, 8'd4);
    exp_q.delete();
    push_frame(8'h3C, 4);
    wr(2'd0, 8'h3C);
    for (int idx = 0; idx < 14; idx++) begin
      e = exp_q.pop_front();
      tick();
      vectors++; if (txd !== e) begin miscompares++; $display("FAIL rstmid_txd[%0d]: got %b want %b", idx, txd, e); end
      dev_wr_b = 1'b1;
      if (idx == 2) begin dev_wr_b = 1'b0; dev_addr = 2'd0; wdata = 8'h11; end
    end
    exp_q.delete();
    rst = 1'b1;
    tick();
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL rstmid_txd: got %b want 1", txd); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    rst = 1'b0;
    rd(2'd1, d);
    vectors++; if (d !== 8'd0) begin miscompares++; $display("FAIL rstmid_count: got %0d want 0", d); end
    rd(2'd2, d);
    vectors++; if (d !== 8'd16) begin miscompares++; $display("FAIL rstmid_div: got %0d want 16", d); end
    rd(2'd0, d);
    vectors++; if (d !== (8'h01 | PAR_BIT)) begin miscompares++; $display("FAIL rstmid_status: got %h want %h", d, 8'h01 | PAR_BIT); end
    repeat (3) tick();
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL rstmid_idle_txd: got %b want 1", txd); end
  endtask

`ifdef HB_UART_PARITY_EN
  task automatic test_parity();
    logic [10:0] pat;
    pat = 11'b11000001110;
    wr(2'd1, 8'd1);
    wr(2'd0, 8'h07);
    for (int i = 0; i < 11; i++) begin
      tick();
      vectors++; if (txd !== pat[i]) begin miscompares++; $display("FAIL parity_txd[%0d]: got %b want %b", i, txd, pat[i]); end
    end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL parity_busy_end: got %b want 0", busy); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_divisor_change();
    test_reset_mid();
`ifdef HB_UART_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
